// File: rtl/bcd_to_ac_pkg.sv
// Shared constants and state encoding for the packed-BCD to binary converter.
package bcd_to_ac_pkg;

  localparam int DIGITS_DEF = 3;
  localparam int BIN_W_DEF  = 8;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ        = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when a nibble is a legal decimal digit.
  function automatic logic bcd_digit_ok(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_ac_nibble_adj.sv
// Per-digit correction for reverse double-dabble: after the right shift a
// nibble that reached 8 or more carried in a weight of 8 where decimal needs
// 5, so 3 is removed. Inverse of the display path's +3 corrector.
module bcd_nibble_adj
  import bcd_to_ac_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Subtract 3 from nibbles at or above the threshold, pass others through.
  always_comb begin
    if (nib_i >= ADJ_THRESH) begin
      nib_o = nib_i - ADJ;
    end else begin
      nib_o = nib_i;
    end
  end

endmodule

// File: rtl/bcd_to_ac.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one
// shift/adjust iteration per clock with a start/done handshake. The result
// feeds the AC register from operator-entered decimal digits.
module bcd_to_ac
  import bcd_to_ac_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      dout,
  output logic                  ovf,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     bcd_q;
  logic [W-1:0]     acc_q;
  logic             bad_q;
  logic             busy_q;
  logic             done_q;
  logic [BIN_W-1:0] dout_q;
  logic             ovf_q;
  logic             err_q;

  logic             din_bad_s;
  logic [W-1:0]     bcd_shift_s;
  logic [W-1:0]     bcd_d;
  logic [W-1:0]     acc_d;
  logic [BIN_W-1:0] res_s;
  logic             hi_s;

  // Flag any input digit outside 0..9.
  always_comb begin
    din_bad_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_ok(din[4*i +: 4])) begin
        din_bad_s = 1'b1;
      end else begin
        din_bad_s = din_bad_s;
      end
    end
  end

  // {bcd,acc} shifted right by one: bcd LSB moves into acc MSB.
  assign bcd_shift_s = {1'b0, bcd_q[W-1:1]};
  assign acc_d       = {bcd_q[0], acc_q[W-1:1]};

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (
        .nib_i (bcd_shift_s[4*g +: 4]),
        .nib_o (bcd_d[4*g +: 4])
      );
    end
  endgenerate

  // Fit the accumulator into the output width; bits above BIN_W mean overflow.
  generate
    if (BIN_W < W) begin : g_narrow
      assign res_s = acc_q[BIN_W-1:0];
      assign hi_s  = |acc_q[W-1:BIN_W];
    end else if (BIN_W == W) begin : g_equal
      assign res_s = acc_q;
      assign hi_s  = 1'b0;
    end else begin : g_wide
      assign res_s = {{(BIN_W-W){1'b0}}, acc_q};
      assign hi_s  = 1'b0;
    end
  endgenerate

  // Control FSM, iteration counter, datapath registers and registered outputs.
  // An invalid input spends one cycle in CONV with bad_q set, so both paths
  // enter DONE from CONV and the error result appears one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bcd_q   <= {W{1'b0}};
      acc_q   <= {W{1'b0}};
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= {BIN_W{1'b0}};
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CONV;
            busy_q  <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
            acc_q   <= {W{1'b0}};
            bad_q   <= din_bad_s;
            bcd_q   <= din_bad_s ? {W{1'b0}} : din;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CONV: begin
          if (bad_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            dout_q  <= {BIN_W{1'b0}};
            ovf_q   <= 1'b0;
            err_q   <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            dout_q  <= res_s;
            ovf_q   <= hi_s;
            err_q   <= 1'b0;
          end else begin
            bcd_q <= bcd_d;
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          bad_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          bad_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign ovf  = ovf_q;
  assign err  = err_q;

endmodule
